simple_dual_port_ram_fifo_controller: RTL

//   Sequences an external simple dual-port RAM with registered read (1-cycle read latency) as a synchronous FIFO.

---
 rtl/simple_dual_port_ram_fifo_controller.sv | 102 ++++++++++
 1 files changed

// File: rtl/simple_dual_port_ram_fifo_controller.sv
// Synchronous FIFO controller for an external simple dual-port RAM with 1-cycle read latency.
// A 2-entry prefetch buffer hides the RAM read latency so both sides can move one word per cycle.
module simple_dual_port_ram_fifo_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LEVEL_WIDTH   = $clog2(DEPTH + 3)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_valid,
  output logic                     write_ready,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic [WIDTH-1:0]         read_data,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WIDTH-1:0]         ram_write_data,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data
);

  localparam int CW = ADDRESS_WIDTH + 1;

  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]            ram_count_q, ram_count_d;
  logic                     pending_q;
  logic [1:0]               buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0]         head_q, head_d;
  logic [WIDTH-1:0]         tail_q, tail_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] after_pop;

  always_comb begin
    write_ready = (ram_count_q != CW'(DEPTH));
    push        = resetn & write_valid & write_ready;
    read_valid  = (buf_cnt_q != 2'd0);
    pop         = read_valid & read_ready;
    after_pop   = buf_cnt_q - {1'b0, pop};
    // Only issue when the returning word is guaranteed a free buffer slot.
    issue       = resetn & (ram_count_q != '0) &
                  (({1'b0, after_pop} + {2'b00, pending_q}) <= 3'd1);

    wptr_d      = wptr_q + ADDRESS_WIDTH'(push);
    rptr_d      = rptr_q + ADDRESS_WIDTH'(issue);
    ram_count_d = ram_count_q + CW'(push) - CW'(issue);

    head_d      = head_q;
    tail_d      = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    buf_cnt_d = after_pop;
    // Capture lands after the pop shift, in the first free slot.
    if (pending_q) begin
      if (after_pop == 2'd0) begin
        head_d = ram_read_data;
      end else begin
        tail_d = ram_read_data;
      end
      buf_cnt_d = after_pop + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_count_q <= '0;
      pending_q   <= 1'b0;
      buf_cnt_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_count_q <= ram_count_d;
      pending_q   <= issue;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  always_comb begin
    read_data         = head_q;
    level             = LEVEL_WIDTH'(ram_count_q) + LEVEL_WIDTH'(pending_q) + LEVEL_WIDTH'(buf_cnt_q);
    ram_write_enable  = push;
    ram_write_address = wptr_q;
    ram_write_data    = write_data;
    ram_read_enable   = issue;
    ram_read_address  = rptr_q;
  end

endmodule
